hub75_fb_loader: RTL

//  Sequences the hub75_top frame-buffer write port from a pixel stream (valid/ready, start-of-frame flag).

---
 rtl/hub75_fb_loader_pkg.sv | 7 +
 rtl/hub75_fb_loader.sv | 121 ++++++++++++
 2 files changed

// File: rtl/hub75_fb_loader_pkg.sv
// hub75_fb_loader_pkg: shared widths and helpers for the frame-buffer loader
package hub75_fb_loader_pkg;
  localparam int STAT_W = 16;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/hub75_fb_loader.sv
// hub75_fb_loader: turns a pixel stream into hub75_top line-buffer writes, row commits and frame swaps
module hub75_fb_loader
  import hub75_fb_loader_pkg::*;
#(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int BITDEPTH    = 24,
  parameter int LOG_N_BANKS = clog2_min1(N_BANKS),
  parameter int LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BITDEPTH-1:0]    in_data,
  input  logic                   in_sof,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   ctrl_en,
  output logic [LOG_N_BANKS-1:0] fbw_bank_addr,
  output logic [LOG_N_ROWS-1:0]  fbw_row_addr,
  output logic                   fbw_row_store,
  input  logic                   fbw_row_rdy,
  output logic                   fbw_row_swap,
  output logic [BITDEPTH-1:0]    fbw_data,
  output logic [LOG_N_COLS-1:0]  fbw_col_addr,
  output logic                   fbw_wren,
  output logic                   frame_swap,
  input  logic                   frame_rdy,
  output logic                   stat_busy,
  output logic [STAT_W-1:0]      stat_frames,
  output logic                   stat_resync
);
  localparam int LW = LOG_N_BANKS + LOG_N_ROWS;
  localparam logic [LW-1:0] LAST_LINE = LW'(N_BANKS * N_ROWS - 1);
  localparam logic [LOG_N_COLS-1:0] LAST_COL = LOG_N_COLS'(N_COLS - 1);
  typedef enum logic [2:0] {IDLE, FILL, ROW_WAIT, ROW_COMMIT, FRAME_WAIT, FRAME_SWAP} state_t;
  state_t state;
  logic [LW-1:0] line;
  logic [LOG_N_COLS-1:0] col;
  logic acc;
  assign acc = in_valid && in_ready;
  // in_ready is registered, so every transition sets it for the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      line          <= '0;
      col           <= '0;
      in_ready      <= 1'b0;
      fbw_bank_addr <= '0;
      fbw_row_addr  <= '0;
      fbw_row_store <= 1'b0;
      fbw_row_swap  <= 1'b0;
      fbw_data      <= '0;
      fbw_col_addr  <= '0;
      fbw_wren      <= 1'b0;
      frame_swap    <= 1'b0;
      stat_busy     <= 1'b0;
      stat_frames   <= '0;
      stat_resync   <= 1'b0;
    end else begin
      fbw_wren      <= 1'b0;
      fbw_row_store <= 1'b0;
      fbw_row_swap  <= 1'b0;
      frame_swap    <= 1'b0;
      stat_resync   <= 1'b0;
      if (acc && (in_sof || state == FILL)) begin
        fbw_wren     <= 1'b1;
        fbw_data     <= in_data;
        fbw_col_addr <= in_sof ? '0 : col;
      end
      case (state)
        IDLE: begin
          in_ready <= ctrl_en;
          if (acc && in_sof) begin
            state     <= FILL;
            line      <= '0;
            col       <= LOG_N_COLS'(1);
            in_ready  <= 1'b1;
            stat_busy <= 1'b1;
          end
        end
        FILL: if (acc) begin
          if (in_sof) begin
            stat_resync <= (line != '0) || (col != '0);
            line        <= '0;
            col         <= LOG_N_COLS'(1);
          end else begin
            col <= col + 1'b1;
            if (col == LAST_COL) begin
              state    <= ROW_WAIT;
              in_ready <= 1'b0;
            end
          end
        end
        ROW_WAIT: if (fbw_row_rdy) begin
          state                         <= ROW_COMMIT;
          fbw_row_store                 <= 1'b1;
          fbw_row_swap                  <= 1'b1;
          {fbw_bank_addr, fbw_row_addr} <= line;
        end
        ROW_COMMIT: begin
          state    <= (line == LAST_LINE) ? FRAME_WAIT : FILL;
          in_ready <= (line != LAST_LINE);
          line     <= (line == LAST_LINE) ? line : line + 1'b1;
        end
        FRAME_WAIT: if (frame_rdy && fbw_row_rdy) begin
          state       <= FRAME_SWAP;
          frame_swap  <= 1'b1;
          stat_frames <= stat_frames + 1'b1;
        end
        FRAME_SWAP: begin
          state     <= IDLE;
          stat_busy <= 1'b0;
          in_ready  <= ctrl_en;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
